// File: rtl/wash_seq.sv
// Washing-machine stage sequencer.
// Runs the wash stage as FILL -> WASH -> DRAIN -> SPIN -> DONE for the latched
// programme. It drives the phase lights, the water-level bar and a four-digit
// multiplexed seven-segment display of the phase code and remaining seconds.
module wash_seq #(
   parameter int TICK_CYCLES = 100000000,
   parameter int SCAN_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] mode,
   input  logic       pause_pos,
   output logic [7:0] seg,
   output logic [3:0] seg_en,
   output logic [7:0] st_light,
   output logic [7:0] wt_light,
   output logic       done
);

   localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      WASH  = 3'd2,
      DRAIN = 3'd3,
      SPIN  = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t            state_q, state_d;

   logic [1:0]        mode_q, mode_d;
   logic              paused_q, paused_d;
   logic [TICK_W-1:0] tickCnt_q, tickCnt_d;
   logic [4:0]        remain_q, remain_d;
   logic [7:0]        wtLight_q, wtLight_d;
   logic [3:0]        barCnt_q, barCnt_d;
   logic              done_q, done_d;

   logic [SCAN_W-1:0] scanCnt_q, scanCnt_d;
   logic [1:0]        slot_q, slot_d;

   logic [1:0]        effMode;
   logic [3:0]        target;
   logic [4:0]        washLoad;
   logic [4:0]        spinLoad;

   logic              inRun;
   logic              nextRun;
   logic              tick;
   logic              phaseEntry;
   logic              fillDone;
   logic              washDone;
   logic              drainDone;
   logic              spinDone;

   logic [4:0]        dispRemain;
   logic [3:0]        tensDig;
   logic [3:0]        onesDig;
   logic [3:0]        phaseCode;

   // Standard seven-segment patterns, segment a in bit 0, dp always off
   function automatic logic [7:0] sevenSeg(input logic [3:0] digit);
      logic [7:0] pattern;
      case (digit)
         4'd0:    pattern = 8'h3F;
         4'd1:    pattern = 8'h06;
         4'd2:    pattern = 8'h5B;
         4'd3:    pattern = 8'h4F;
         4'd4:    pattern = 8'h66;
         4'd5:    pattern = 8'h6D;
         4'd6:    pattern = 8'h7D;
         4'd7:    pattern = 8'h07;
         4'd8:    pattern = 8'h7F;
         4'd9:    pattern = 8'h6F;
         default: pattern = 8'h00;
      endcase
      return pattern;
   endfunction

   assign inRun      = (state_q == FILL) || (state_q == WASH) ||
                       (state_q == DRAIN) || (state_q == SPIN);
   assign nextRun    = (state_d == FILL) || (state_d == WASH) ||
                       (state_d == DRAIN) || (state_d == SPIN);
   assign tick       = inRun && !paused_q && (tickCnt_q == TICK_LAST);
   assign phaseEntry = (state_d != state_q);

   assign fillDone   = tick && (barCnt_q == (target - 4'd1));
   assign washDone   = tick && (remain_q == 5'd1);
   assign drainDone  = tick && (barCnt_q == 4'd1);
   assign spinDone   = tick && (remain_q == 5'd1);

   assign done       = done_q;

   // Programme constants; while idle the live mode is used because it is latched on the same edge
   always_comb begin
      effMode  = (state_q == IDLE) ? mode : mode_q;
      target   = 4'd0;
      washLoad = 5'd0;
      case (effMode)
         2'b01: begin
            target   = 4'd3;
            washLoad = 5'd10;
         end
         2'b10: begin
            target   = 4'd5;
            washLoad = 5'd15;
         end
         2'b11: begin
            target   = 4'd8;
            washLoad = 5'd20;
         end
         default: begin
            target   = 4'd0;
            washLoad = 5'd0;
         end
      endcase
      spinLoad = (effMode == 2'b00) ? 5'd10 : 5'd5;
   end

   // Phase state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Phase sequencing; dropping en aborts to IDLE from anywhere and beats a pause request
   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = (mode == 2'b00) ? SPIN : FILL;
            FILL:    if (fillDone)  state_d = WASH;
            WASH:    if (washDone)  state_d = DRAIN;
            DRAIN:   if (drainDone) state_d = SPIN;
            SPIN:    if (spinDone)  state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Phase lights, water bar and the multiplexed digit currently being scanned
   always_comb begin
      st_light = 8'h00;
      wt_light = 8'h00;
      seg      = 8'h00;
      seg_en   = 4'h0;
      case (state_q)
         FILL:    st_light = 8'h08;
         WASH:    st_light = 8'h10;
         DRAIN:   st_light = 8'h20;
         SPIN:    st_light = 8'h40;
         default: st_light = 8'h00;
      endcase
      if (inRun) begin
         st_light[7] = paused_q;
      end
      if (state_q != IDLE) begin
         wt_light = wtLight_q;
         seg_en   = 4'b0001 << slot_q;
         case (slot_q)
            2'd3:    seg = sevenSeg(phaseCode);
            2'd2:    seg = 8'h00;
            2'd1:    seg = sevenSeg(tensDig);
            default: seg = sevenSeg(onesDig);
         endcase
      end
   end

   // Seconds shown on the display, derived per phase, then split into two BCD digits
   always_comb begin
      dispRemain = 5'd0;
      phaseCode  = 4'd0;
      case (state_q)
         FILL: begin
            dispRemain = {1'b0, target - barCnt_q};
            phaseCode  = 4'd1;
         end
         WASH: begin
            dispRemain = remain_q;
            phaseCode  = 4'd2;
         end
         DRAIN: begin
            dispRemain = {1'b0, barCnt_q};
            phaseCode  = 4'd3;
         end
         SPIN: begin
            dispRemain = remain_q;
            phaseCode  = 4'd4;
         end
         default: begin
            dispRemain = 5'd0;
            phaseCode  = 4'd0;
         end
      endcase
      if (dispRemain >= 5'd20) begin
         tensDig = 4'd2;
         onesDig = 4'(dispRemain - 5'd20);
      end else if (dispRemain >= 5'd10) begin
         tensDig = 4'd1;
         onesDig = 4'(dispRemain - 5'd10);
      end else begin
         tensDig = 4'd0;
         onesDig = 4'(dispRemain);
      end
   end

   // Next values for mode latch, pause flag, tick counter, countdown and water level
   always_comb begin
      mode_d    = mode_q;
      paused_d  = paused_q;
      tickCnt_d = tickCnt_q;
      remain_d  = remain_q;
      wtLight_d = wtLight_q;
      barCnt_d  = barCnt_q;
      done_d    = 1'b0;
      if (!en) begin
         paused_d  = 1'b0;
         tickCnt_d = '0;
         remain_d  = 5'd0;
         wtLight_d = 8'h00;
         barCnt_d  = 4'd0;
      end else begin
         if (state_q == IDLE) begin
            mode_d = mode;
         end

         if (!nextRun) begin
            paused_d = 1'b0;
         end else if (inRun && pause_pos) begin
            paused_d = !paused_q;
         end

         if (phaseEntry || !inRun) begin
            tickCnt_d = '0;
         end else if (!paused_q) begin
            tickCnt_d = tick ? '0 : tickCnt_q + TICK_W'(1);
         end

         if (phaseEntry && (state_d == WASH)) begin
            remain_d = washLoad;
         end else if (phaseEntry && (state_d == SPIN)) begin
            remain_d = spinLoad;
         end else if (tick && ((state_q == WASH) || (state_q == SPIN))) begin
            remain_d = remain_q - 5'd1;
         end

         if (tick && (state_q == FILL)) begin
            wtLight_d = {wtLight_q[6:0], 1'b1};
            barCnt_d  = barCnt_q + 4'd1;
         end else if (tick && (state_q == DRAIN)) begin
            wtLight_d = wtLight_q >> 1;
            barCnt_d  = barCnt_q - 4'd1;
         end

         done_d = (state_q == SPIN) && (state_d == DONE);
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q    <= 2'b00;
         paused_q  <= 1'b0;
         tickCnt_q <= '0;
         remain_q  <= 5'd0;
         wtLight_q <= 8'h00;
         barCnt_q  <= 4'd0;
         done_q    <= 1'b0;
      end else begin
         mode_q    <= mode_d;
         paused_q  <= paused_d;
         tickCnt_q <= tickCnt_d;
         remain_q  <= remain_d;
         wtLight_q <= wtLight_d;
         barCnt_q  <= barCnt_d;
         done_q    <= done_d;
      end
   end

   // Digit scan timing; held at slot 0 while idle so every run starts scanning from digit 0
   always_comb begin
      scanCnt_d = scanCnt_q;
      slot_d    = slot_q;
      if ((state_q == IDLE) || (state_d == IDLE)) begin
         scanCnt_d = '0;
         slot_d    = 2'd0;
      end else if (scanCnt_q == SCAN_LAST) begin
         scanCnt_d = '0;
         slot_d    = slot_q + 2'd1;
      end else begin
         scanCnt_d = scanCnt_q + SCAN_W'(1);
      end
   end

   // Scan registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scanCnt_q <= '0;
         slot_q    <= 2'd0;
      end else begin
         scanCnt_q <= scanCnt_d;
         slot_q    <= slot_d;
      end
   end

endmodule
